clause_fetch_sequencer: RTL and testbench
=========================================

// Module: clause_fetch_sequencer
// PURPOSE
//   Runtime stage directly downstream of the address translation table (ATT). Accepts one literal
//   address at a time, drives the ATT read port, and captures the returned clause-table address
//   and CLAUSE_COUNT-bit mask. It then emits one (clause address, slot index) pair per set mask
//   bit over a valid/ready stream toward the clause evaluation logic.
// PARAMETERS
//   CLAUSE_COUNT               20  mask width; slots per clause-table word
//   LITERAL_ADDRESS_WIDTH      12  literal address is LITERAL_ADDRESS_WIDTH+1 bits (ATT port width)
//   CLAUSE_TABLE_ADDRESS_WIDTH 11  clause-table word address width
//   SLOT_W  (localparam)           $clog2(CLAUSE_COUNT)
// PORTS
//   clk_i          in   1      clock; all state on rising edge
//   rst_ni         in   1      asynchronous, active-low reset
//   flush_i        in   1      synchronous abort of the current literal
//   lit_valid_i    in   1      literal request valid
//   lit_ready_o    out  1      high only in IDLE
//   lit_addr_i     in   LAW+1  literal address
//   att_rd_addr_o  out  LAW+1  to ATT rd_addr_i; = lit_addr_i in IDLE, else held lit_q
//   att_addr_i     in   CTAW   from ATT addr_o (valid 1 cycle after rd addr sampled)
//   att_mask_i     in   CC     from ATT mask_o
//   cl_valid_o     out  1      clause pair valid
//   cl_ready_i     in   1      downstream accept
//   cl_addr_o      out  CTAW   clause-table word address (constant for one literal)
//   cl_slot_o      out  SLOT_W index of the lowest remaining set mask bit
//   cl_last_o      out  1      exactly one mask bit remains
//   done_o         out  1      1-cycle pulse: literal fully processed (incl. empty mask)
// BEHAVIOUR
//   Reset: state=IDLE, lit_q=0, mask_q=0, addr_q=0; cl_valid_o=0, done_o=0, lit_ready_o=1.
//   FSM IDLE -> WAIT -> EMIT -> IDLE.
//   IDLE: lit_ready_o=1. On lit_valid_i & lit_ready_o: lit_q<=lit_addr_i, go WAIT.
//     ATT samples att_rd_addr_o on this same edge.
//   WAIT: ATT output is valid; addr_q<=att_addr_i, mask_q<=att_mask_i.
//     If att_mask_i==0: done_o=1 next cycle, go IDLE. Otherwise go EMIT.
//   EMIT: cl_valid_o=1; cl_slot_o=lowest set bit of mask_q; cl_last_o=(mask_q has one bit set).
//     On cl_valid_o & cl_ready_i: clear that bit. If it was the last, pulse done_o and go IDLE.
//     cl_valid_o=1 with !cl_ready_i: outputs held stable; no bits cleared.
//   Latency: accept at edge N; first cl_valid_o in cycle after edge N+1 (2 cycles).
//     Throughput is 1 pair/cycle under constant ready. Next literal is accepted the cycle after done_o.
//   Ordering: slots are emitted LSB first. Mask bits >= CLAUSE_COUNT do not exist.
//     A full mask (all ones) yields CLAUSE_COUNT pairs.
//   flush_i (priority over all handshakes): next state IDLE, mask_q<=0, no done_o.
//     A same-cycle lit_valid_i is not accepted.
//   Async reset mid-EMIT: cl_valid_o drops immediately. The in-flight literal is lost.
//   done_o and cl_valid_o are never high in the same cycle.
// CONFIGURATION
//   CLAUSE_FETCH_PERF_EN defined: adds outputs perf_lits_o[31:0] and perf_clauses_o[31:0].
//     Both are saturating counters (stick at 32'hFFFF_FFFF).
//     perf_lits_o counts accepted literals. perf_clauses_o counts cl handshakes.
//     Both reset to 0; flush does not clear them.
//   Undefined: ports and counters are absent. Functional behaviour is otherwise identical.
// STRUCTURE
//   Package sat_fetch_pkg: FSM state localparams (IDLE=2'd0, WAIT=2'd1, EMIT=2'd2) and the
//     SLOT_W derivation function. The package is shared with the clause evaluator.
//   Sub-module lowest_set_bit_encoder #(WIDTH): combinational.
//     Outputs: index, one-hot of lowest set bit (for clearing), and the single_bit flag.
// TESTING
//   1. Mask 20'h00005, addr 11'h07A, ready=1 -> pairs (07A,0,last=0),(07A,2,last=1); done_o 1 cycle later.
//   2. Mask 0 -> no cl_valid_o; done_o pulses 2 cycles after accept; lit_ready_o high next cycle.
//   3. Mask 20'hFFFFF, ready toggling 1/0 -> 20 pairs, slots 0..19 in order.
//      Outputs are stable while stalled; last only on slot 19.
//   4. flush_i in EMIT after 1 of 3 pairs -> cl_valid_o low next cycle, no done_o.
//      Next literal is processed cleanly.
//   5. Assert rst_ni low mid-EMIT -> cl_valid_o falls without a clock edge; state IDLE on release.
//   6. With CLAUSE_FETCH_PERF_EN: run tests 1+3 -> perf_lits_o=2, perf_clauses_o=22.
//      A counter preset near 32'hFFFF_FFFF saturates.

Source files
------------

// File: rtl/sat_fetch_pkg.sv
// Shared definitions for the clause fetch path: FSM state encoding and slot index width.
// Also used by the clause evaluator.
package sat_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } fetch_state_e;

    function automatic int slot_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational lowest-set-bit encoder: index, isolating one-hot, and single-bit flag.
module lowest_set_bit_encoder
    import sat_fetch_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int IDX_W = slot_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_index,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_single
);

    logic [WIDTH-1:0] w_rest;

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
    assign w_rest   = i_vec & ~o_onehot;
    assign o_single = (i_vec != '0) && (w_rest == '0);

    always_comb begin
        o_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/clause_fetch_sequencer.sv
// Reads the ATT for one literal and emits one (clause address, slot) pair per set mask bit, LSB first.
// Optional CLAUSE_FETCH_PERF_EN adds saturating literal/clause performance counters.
module clause_fetch_sequencer
    import sat_fetch_pkg::*;
#(
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  lit_valid_i,
    output logic                                  lit_ready_o,
    input  logic [LITERAL_ADDRESS_WIDTH:0]        lit_addr_i,
    output logic [LITERAL_ADDRESS_WIDTH:0]        att_rd_addr_o,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i,
    input  logic [CLAUSE_COUNT-1:0]               att_mask_i,
    output logic                                  cl_valid_o,
    input  logic                                  cl_ready_i,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] cl_addr_o,
    output logic [slot_width(CLAUSE_COUNT)-1:0]   cl_slot_o,
    output logic                                  cl_last_o,
    output logic                                  done_o
`ifdef CLAUSE_FETCH_PERF_EN
    ,
    output logic [31:0]                           perf_lits_o,
    output logic [31:0]                           perf_clauses_o
`endif
);

    localparam int SLOT_W = slot_width(CLAUSE_COUNT);

    fetch_state_e                          r_state;
    fetch_state_e                          w_state_nxt;
    logic [LITERAL_ADDRESS_WIDTH:0]        r_lit;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] r_addr;
    logic [CLAUSE_COUNT-1:0]               r_mask;
    logic [CLAUSE_COUNT-1:0]               w_mask_nxt;
    logic                                  r_done;
    logic                                  w_done_nxt;
    logic [SLOT_W-1:0]                     w_slot;
    logic [CLAUSE_COUNT-1:0]               w_lowest;
    logic                                  w_single;
    logic                                  w_lit_acc;
    logic                                  w_cl_hs;

    lowest_set_bit_encoder #(
        .WIDTH (CLAUSE_COUNT),
        .IDX_W (SLOT_W)
    ) u_lsb (
        .i_vec    (r_mask),
        .o_index  (w_slot),
        .o_onehot (w_lowest),
        .o_single (w_single)
    );

    // Holding ready low during the done pulse defers the next literal by one cycle.
    assign lit_ready_o   = (r_state == ST_IDLE) && !r_done;
    assign w_lit_acc     = lit_valid_i && lit_ready_o && !flush_i;
    assign cl_valid_o    = (r_state == ST_EMIT);
    assign w_cl_hs       = cl_valid_o && cl_ready_i && !flush_i;
    assign att_rd_addr_o = (r_state == ST_IDLE) ? lit_addr_i : r_lit;
    assign cl_addr_o     = r_addr;
    assign cl_slot_o     = w_slot;
    assign cl_last_o     = w_single;
    assign done_o        = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lit_acc) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_mask_nxt = att_mask_i;
                if (att_mask_i == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_cl_hs) begin
                    w_mask_nxt = r_mask & ~w_lowest;
                    if (w_single) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            w_mask_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_lit   <= '0;
            r_mask  <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_done  <= w_done_nxt;
            if (w_lit_acc) begin
                r_lit <= lit_addr_i;
            end
            if (r_state == ST_WAIT) begin
                r_addr <= att_addr_i;
            end
        end
    end

`ifdef CLAUSE_FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_lits;
    logic [31:0] r_perf_clauses;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_lits    <= '0;
            r_perf_clauses <= '0;
        end else begin
            if (w_lit_acc) begin
                r_perf_lits <= sat_inc(r_perf_lits);
            end
            if (w_cl_hs) begin
                r_perf_clauses <= sat_inc(r_perf_clauses);
            end
        end
    end

    assign perf_lits_o    = r_perf_lits;
    assign perf_clauses_o = r_perf_clauses;
`endif

endmodule

// File: tb/tb_clause_fetch_sequencer.sv
// Bench for clause_fetch_sequencer: table-driven literals, an ATT model, and a pair scoreboard.
module tb_clause_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        lit_valid_i;
    logic        lit_ready_o;
    logic [12:0] lit_addr_i;
    logic [12:0] att_rd_addr_o;
    logic [10:0] att_addr_i;
    logic [19:0] att_mask_i;
    logic        cl_valid_o;
    logic        cl_ready_i;
    logic [10:0] cl_addr_o;
    logic [4:0]  cl_slot_o;
    logic        cl_last_o;
    logic        done_o;
`ifdef CLAUSE_FETCH_PERF_EN
    logic [31:0] perf_lits_o;
    logic [31:0] perf_clauses_o;
`endif

    clause_fetch_sequencer dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .lit_valid_i   (lit_valid_i),
        .lit_ready_o   (lit_ready_o),
        .lit_addr_i    (lit_addr_i),
        .att_rd_addr_o (att_rd_addr_o),
        .att_addr_i    (att_addr_i),
        .att_mask_i    (att_mask_i),
        .cl_valid_o    (cl_valid_o),
        .cl_ready_i    (cl_ready_i),
        .cl_addr_o     (cl_addr_o),
        .cl_slot_o     (cl_slot_o),
        .cl_last_o     (cl_last_o),
        .done_o        (done_o)
`ifdef CLAUSE_FETCH_PERF_EN
        ,
        .perf_lits_o   (perf_lits_o),
        .perf_clauses_o(perf_clauses_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ATT model: one-cycle registered lookup keyed by the sampled read address.
    logic [10:0] att_a_tab [0:8191];
    logic [19:0] att_m_tab [0:8191];
    logic [12:0] r_att_rd;
    always @(posedge clk_i) r_att_rd <= att_rd_addr_o;
    assign att_addr_i = att_a_tab[r_att_rd];
    assign att_mask_i = att_m_tab[r_att_rd];

    typedef struct {
        logic [12:0] lit;
        logic [10:0] addr;
        logic [19:0] mask;
        int          rmode;
        int          exp_pairs;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] sb [$];
    int          ready_mode = 0;
    logic        in_wait = 0, exp_valid = 0, exp_done = 0, stalled = 0, done_prev = 0;
    logic        cur_empty = 0, accepted = 0, saw_done = 0;
    logic [16:0] prev_pair = '0;
    int          lit_pairs = 0, hs_total = 0, n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic        hs, acc, pop_last, exp_done_n;
        logic [16:0] cur, e;
        hs       = cl_valid_o && cl_ready_i && !flush_i;
        acc      = lit_valid_i && lit_ready_o && !flush_i;
        cur      = {cl_addr_o, cl_slot_o, cl_last_o};
        pop_last = 1'b0;
        chk("done_timing", done_o, exp_done);
        chk("done_valid_excl", done_o && cl_valid_o, 1'b0);
        if (in_wait) chk("wait_no_valid", cl_valid_o, 1'b0);
        if (exp_valid) chk("first_valid_latency", cl_valid_o, 1'b1);
        if (done_prev) chk("ready_after_done", lit_ready_o, 1'b1);
        if (stalled) begin
            chk("stall_valid_held", cl_valid_o, 1'b1);
            chk("stall_pair_held", cur, prev_pair);
        end
        if (hs) begin
            chk("pair_available", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pair", cur, e);
                pop_last = e[0];
            end
            lit_pairs++;
            hs_total++;
        end
        exp_done_n = (hs && pop_last) || (in_wait && cur_empty && !flush_i);
        exp_valid  = in_wait && !cur_empty && !flush_i;
        in_wait    = acc;
        if (acc) begin
            accepted = 1'b1;
            n_acc++;
        end
        stalled   = cl_valid_o && !cl_ready_i && !flush_i;
        prev_pair = cur;
        done_prev = done_o;
        if (done_o) saw_done = 1'b1;
        exp_done  = exp_done_n;
        if (flush_i) sb.delete();
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        case (ready_mode)
            0:       cl_ready_i = 1'b1;
            1:       cl_ready_i = ~cl_ready_i;
            default: cl_ready_i = 1'b0;
        endcase
    endtask

    task automatic start_lit(input logic [12:0] lit, input logic [10:0] a, input logic [19:0] m);
        int cyc;
        att_a_tab[lit] = a;
        att_m_tab[lit] = m;
        cur_empty = (m == '0);
        for (int i = 0; i < 20; i++) begin
            if (m[i]) sb.push_back({a, 5'(i), ((m >> (i + 1)) == 20'd0)});
        end
        lit_pairs   = 0;
        saw_done    = 1'b0;
        accepted    = 1'b0;
        lit_addr_i  = lit;
        lit_valid_i = 1'b1;
        cyc = 0;
        while (!accepted && cyc < 50) begin
            tick();
            cyc++;
        end
        lit_valid_i = 1'b0;
        chk("literal_accepted", accepted, 1'b1);
    endtask

    task automatic send_lit(input logic [12:0] lit, input logic [10:0] a, input logic [19:0] m,
                            output int pairs);
        int cyc;
        start_lit(lit, a, m);
        cyc = 0;
        while (!saw_done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_seen", saw_done, 1'b1);
        chk("queue_drained", sb.size(), 0);
        pairs = lit_pairs;
    endtask

    initial begin
        vec_t vt [6];
        int   pairs, cyc, h0;

        vt[0] = '{13'h0005, 11'h07A, 20'h00005, 0, 2};
        vt[1] = '{13'h0006, 11'h011, 20'h00000, 0, 0};
        vt[2] = '{13'h0107, 11'h3C5, 20'hFFFFF, 1, 20};
        vt[3] = '{13'h1FFF, 11'h7FF, 20'h80000, 0, 1};
        vt[4] = '{13'h0A00, 11'h001, 20'h00001, 1, 1};
        vt[5] = '{13'h0123, 11'h456, 20'hA5A5A, 1, 10};

        for (int i = 0; i < 8192; i++) begin
            att_a_tab[i] = '0;
            att_m_tab[i] = '0;
        end
        rst_ni = 1'b0; flush_i = 1'b0; lit_valid_i = 1'b0; lit_addr_i = '0; cl_ready_i = 1'b1;
        #1;
        chk("rst_cl_valid", cl_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_lit_ready", lit_ready_o, 1'b1);
        chk("rst_att_passthru", att_rd_addr_o, lit_addr_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 6; i++) begin
            ready_mode = vt[i].rmode;
            cl_ready_i = 1'b1;
            send_lit(vt[i].lit, vt[i].addr, vt[i].mask, pairs);
            chk("pair_count", pairs, vt[i].exp_pairs);
`ifdef CLAUSE_FETCH_PERF_EN
            if (i == 2) begin
                chk("perf_lits_t1_t3", perf_lits_o, 32'd3);
                chk("perf_clauses_t1_t3", perf_clauses_o, 32'd22);
            end
`endif
        end

        // Flush after the first of three pairs.
        ready_mode = 0;
        cl_ready_i = 1'b1;
        start_lit(13'h0030, 11'h155, 20'h00013);
        h0 = hs_total;
        cyc = 0;
        while (hs_total == h0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("flush_pre_pairs", lit_pairs, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_valid_low", cl_valid_o, 1'b0);
        tick();
        tick();
        chk("flush_no_done", saw_done, 1'b0);
        send_lit(13'h0031, 11'h0F0, 20'h00006, pairs);
        chk("post_flush_pairs", pairs, 2);

        // Asynchronous reset while stalled in EMIT.
        ready_mode = 2;
        cl_ready_i = 1'b0;
        start_lit(13'h0041, 11'h2AA, 20'hFFFFF);
        cyc = 0;
        while (!cl_valid_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rst_pre_valid", cl_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_valid_drop", cl_valid_o, 1'b0);
        chk("async_done_low", done_o, 1'b0);
        sb.delete();
        in_wait = 0; exp_valid = 0; exp_done = 0; stalled = 0; done_prev = 0;
        n_acc = 0; hs_total = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_ready", lit_ready_o, 1'b1);
        chk("post_rst_valid", cl_valid_o, 1'b0);
        ready_mode = 0;
        cl_ready_i = 1'b1;
        send_lit(13'h0042, 11'h0AB, 20'h40001, pairs);
        chk("post_rst_pairs", pairs, 2);

`ifdef CLAUSE_FETCH_PERF_EN
        chk("perf_lits", perf_lits_o, n_acc);
        chk("perf_clauses", perf_clauses_o, hs_total);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
